int_ctrl: RTL
=============

// Module: int_ctrl
// PURPOSE
//  Interrupt source for the PC unit's forced-address port (in_force/in_faddr): latches IRQ edges, masks and
//  prioritises them, and injects handler vectors into the PC. Keeps a LIFO of return PCs (EPCs) for nesting.
//  On ERET it forces the PC back to the saved EPC. Sits beside the PC unit; CPU top wires out_force/out_faddr to it.
// PARAMETERS
//  NUM_IRQ    3            number of IRQ lines; index 0 = highest priority
//  DEPTH      3            max nesting depth (EPC stack entries), >=1
//  VEC_BASE   32'h00000100 handler address for IRQ 0
//  VEC_STRIDE 32'h00000010 address step between consecutive IRQ handlers
// PORTS
//  in_CLOCK     in  1        clock, all state changes on rising edge
//  in_RST       in  1        synchronous active-high reset
//  in_irq       in  NUM_IRQ  raw request lines; rising edge = request
//  in_mask_we   in  1        write in_mask_d into mask register
//  in_mask_d    in  NUM_IRQ  new mask (1 = enabled)
//  in_EN        in  1        CPU advancing this cycle (PC enable)
//  in_branch    in  1        current instruction redirects PC (out_JS|J|JR of PC unit)
//  in_ERET      in  1        ERET instruction executing this cycle
//  in_pc        in  32       current PC (PC unit out_pcout)
//  out_force    out 1        to PC in_force; load out_faddr at next edge
//  out_faddr    out 32       to PC in_faddr
//  out_pending  out NUM_IRQ  latched, not-yet-serviced requests
//  out_active   out NUM_IRQ  in-service lines (one bit per stacked level)
//  out_level    out clog2(DEPTH+1)  current nesting depth
//  out_err      out 1        sticky: ERET with empty stack
// BEHAVIOUR
//  Reset: pending=0, mask=all 1, active=0, level=0, stack cleared, out_err=0, irq edge regs=0.
//  out_force=0 and out_faddr=0 while in_RST=1.
//  Edge detect: rise[i] = in_irq[i] & ~irq_q[i]; irq_q <= in_irq every cycle.
//  Eligible: pending & mask, and i numerically below the lowest set index of active (none active = all pass).
//  Winner = lowest eligible index.
//  Inject condition (combinational, same cycle): winner exists & level<DEPTH & in_EN & ~in_branch & ~in_ERET
//    & ~in_mask_we.
//    -> out_force=1, out_faddr=VEC_BASE+winner*VEC_STRIDE (32-bit, wraps mod 2^32).
//    At edge: push in_pc+4 (wrap mod 2^32), level++, active[winner]=1, pending[winner]=0.
//  ERET: in_ERET & level>0 -> out_force=1, out_faddr=top EPC.
//    At edge: pop, level--, clear the active bit pushed at that level.
//    in_ERET & level==0 -> no force, out_err<=1, state otherwise unchanged.
//  ERET has priority over injection in the same cycle; the pending request is taken on a later eligible cycle.
//  pending_next = (pending & ~grant) | rise. A new edge on the line being granted re-sets its pending bit.
//  Mask write takes effect next cycle; masked requests stay pending.
//  level==DEPTH: no injection; requests stay pending until an ERET frees a level.
//  in_RST mid-handler: all state lost; EPCs discarded; no force issued in the reset cycle.
//  Latency: edge on in_irq at cycle n -> pending at n+1 -> earliest out_force in cycle n+1 -> PC = vector after edge n+1.
//  Level state: 0 = IDLE, 1..DEPTH-1 = NESTED, DEPTH = FULL.
//    Transitions: inject +1, ERET -1, reset -> IDLE; otherwise hold.
// STRUCTURE
//  Package int_pkg: localparams for priority-encoder width, level width, state encodings (IDLE/NESTED/FULL).
//  Sub-module epc_stack: DEPTH x (32-bit EPC + irq index) LIFO.
//    Interface: push/pop/top/count; simultaneous push+pop is illegal by construction.
//  Top holds edge detect, pending/mask, priority encoder, vector arithmetic, force mux.
// TESTING
//  1 Reset, pulse in_irq[1], in_EN=1, in_pc=0x40 -> out_force=1, out_faddr=0x110; next cycle level=1, active=3'b010.
//  2 In IRQ1 handler (pc=0x114), raise irq0 -> force 0x100, stack=[0x44,0x118];
//    ERET -> 0x118; ERET -> 0x44; level=0.
//  3 In IRQ0 handler, raise irq2 -> no force, pending=3'b100; after ERET, next eligible cycle forces 0x120.
//  4 irq0 edge with in_branch=1 for 3 cycles -> no force; first cycle with in_branch=0 forces 0x100, EPC=in_pc+4.
//  5 DEPTH=1, IRQ1 active, raise irq0 -> held pending until ERET; ERET+pending same cycle -> ERET target first.
//  6 ERET at level 0 -> out_force=0, out_err=1 sticky until in_RST; in_RST mid-handler -> level=0, active=0.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and sizing helpers for the interrupt controller and its EPC stack.
package int_pkg;

  typedef enum logic [1:0] {
    LVL_IDLE   = 2'd0,
    LVL_NESTED = 2'd1,
    LVL_FULL   = 2'd2
  } lvl_state_t;

  localparam int NUM_IRQ_DEF = 3;
  localparam int DEPTH_DEF   = 3;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int IRQ_W_DEF = idx_w(NUM_IRQ_DEF);
  localparam int LVL_W_DEF = lvl_w(DEPTH_DEF);

endpackage

// File: rtl/epc_stack.sv
// LIFO of return PCs, each entry tagged with the IRQ line that pushed it.
module epc_stack
  import int_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IRQ_W = IRQ_W_DEF,
  parameter int CNT_W = LVL_W_DEF
) (
  input  logic             in_CLOCK,
  input  logic             in_RST,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      push_pc,
  input  logic [IRQ_W-1:0] push_irq,
  output logic [31:0]      top_pc,
  output logic [IRQ_W-1:0] top_irq,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      pc_mem  [DEPTH];
  logic [IRQ_W-1:0] irq_mem [DEPTH];
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] top_idx;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign top_idx = count - 1'b1;

  always_ff @(posedge in_CLOCK) begin
    if (in_RST) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + 1'b1;
    end else if (do_pop) begin
      count <= count - 1'b1;
    end
  end

  // Entries carry no reset; count alone decides which of them are live.
  always_ff @(posedge in_CLOCK) begin
    if (do_push && !in_RST) begin
      pc_mem[count]  <= push_pc;
      irq_mem[count] <= push_irq;
    end
  end

  assign top_pc  = (count == '0) ? 32'h0 : pc_mem[top_idx];
  assign top_irq = (count == '0) ? '0    : irq_mem[top_idx];

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches IRQ edges, masks and prioritises them, and drives the
// PC unit's forced-address port with handler vectors or saved return PCs.
module int_ctrl
  import int_pkg::*;
#(
  parameter int          NUM_IRQ    = NUM_IRQ_DEF,
  parameter int          DEPTH      = DEPTH_DEF,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic                       in_CLOCK,
  input  logic                       in_RST,
  input  logic [NUM_IRQ-1:0]         in_irq,
  input  logic                       in_mask_we,
  input  logic [NUM_IRQ-1:0]         in_mask_d,
  input  logic                       in_EN,
  input  logic                       in_branch,
  input  logic                       in_ERET,
  input  logic [31:0]                in_pc,
  output logic                       out_force,
  output logic [31:0]                out_faddr,
  output logic [NUM_IRQ-1:0]         out_pending,
  output logic [NUM_IRQ-1:0]         out_active,
  output logic [$clog2(DEPTH+1)-1:0] out_level,
  output logic                       out_err
);

  localparam int IRQ_W = idx_w(NUM_IRQ);
  localparam int LVL_W = lvl_w(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] grant;
  logic               err_q;
  logic               win_vld;
  logic [IRQ_W-1:0]   win_idx;
  logic               inject;
  logic               eret_go;
  logic [31:0]        vec_addr;
  logic [31:0]        top_pc;
  logic [IRQ_W-1:0]   top_irq;
  logic [LVL_W-1:0]   level;
  lvl_state_t         state;
  lvl_state_t         state_nxt;

  assign rise = in_irq & ~irq_q;

  // A line is eligible only if it outranks every line already in service.
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    elig    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      blocked = blocked | active[i];
      elig[i] = pending[i] & mask[i] & ~blocked;
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win_idx = IRQ_W'(i);
      end
    end
  end

  assign inject   = win_vld & (state != LVL_FULL) & in_EN & ~in_branch & ~in_ERET
                  & ~in_mask_we & ~in_RST;
  assign eret_go  = in_ERET & (level != '0) & ~in_RST;
  assign grant    = inject ? (NUM_IRQ'(1) << win_idx) : '0;
  assign vec_addr = VEC_BASE + VEC_STRIDE * {{(32-IRQ_W){1'b0}}, win_idx};

  assign out_force   = inject | eret_go;
  assign out_faddr   = eret_go ? top_pc : (inject ? vec_addr : 32'h0);
  assign out_pending = pending;
  assign out_active  = active;
  assign out_level   = level;
  assign out_err     = err_q;

  always_comb begin
    state_nxt = state;
    if (inject) begin
      state_nxt = (level + 1'b1 == FULL_LVL) ? LVL_FULL : LVL_NESTED;
    end else if (eret_go) begin
      state_nxt = (level == ONE_LVL) ? LVL_IDLE : LVL_NESTED;
    end
  end

  always_ff @(posedge in_CLOCK) begin
    if (in_RST) begin
      state <= LVL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge in_CLOCK) begin
    if (in_RST) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '1;
      active  <= '0;
      err_q   <= 1'b0;
    end else begin
      irq_q   <= in_irq;
      pending <= (pending & ~grant) | rise;
      if (in_mask_we) begin
        mask <= in_mask_d;
      end
      if (inject) begin
        active[win_idx] <= 1'b1;
      end else if (eret_go) begin
        active[top_irq] <= 1'b0;
      end
      if (in_ERET && (level == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  epc_stack #(
    .DEPTH (DEPTH),
    .IRQ_W (IRQ_W),
    .CNT_W (LVL_W)
  ) u_epc_stack (
    .in_CLOCK (in_CLOCK),
    .in_RST   (in_RST),
    .push     (inject),
    .pop      (eret_go),
    .push_pc  (in_pc + 32'd4),
    .push_irq (win_idx),
    .top_pc   (top_pc),
    .top_irq  (top_irq),
    .count    (level)
  );

endmodule
